// File: rtl/mem_pkg.sv
// Shared types and constants for the data_memory arbiter.
// Holds the address/data widths, the frame-buffer depth, the response tag carried
// through the read pipeline, and an address range helper.
package mem_pkg;

  localparam int unsigned ADDR_W    = 19;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned MEM_DEPTH = 307200;  // one 640x480 byte frame

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  // Per-read bookkeeping that travels alongside the memory read latency.
  typedef struct packed {
    logic valid;  // a granted read occupies this slot
    logic id;     // issuing port (0 = load/store unit, 1 = frame streamer)
    logic oor;    // address was out of range; data must be suppressed
  } rsp_tag_t;

  // Unsigned compare widened to 32 bits so that depth may equal 2**ADDR_W.
  function automatic logic addr_in_range(addr_t addr, int unsigned depth);
    return {{(32 - ADDR_W){1'b0}}, addr} < depth;
  endfunction

endpackage

// File: rtl/rsp_pipe.sv
// Response tag delay line for the data_memory arbiter.
// Delays each issued tag by STAGES cycles so it lines up with the memory read data.
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low clear; discards all in-flight tags
//   tag_in  - tag entering stage 0 at the end of the grant cycle
//   tag_out - tag leaving the last stage (valid in grant cycle + STAGES)
module rsp_pipe
  import mem_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  rsp_tag_t tag_in,
  output rsp_tag_t tag_out
);

  rsp_tag_t [STAGES-1:0] stage_q;
  rsp_tag_t [STAGES-1:0] stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = tag_in;
    for (int unsigned i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tag_out = stage_q[STAGES-1];

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data_memory.
// Port 0 is the processor load/store unit, port 1 the frame streaming reader/writer.
// One access is granted per cycle; on contention the port not granted last wins.
// Out-of-range writes are dropped (err pulses with gnt); out-of-range reads are still
// issued to keep latency fixed but return rdata=0 with err=1.
// Ports:
//   clk, rst_n                    - clock and asynchronous active-low reset
//   pN_req/we/addr/wdata          - request from port N, held until pN_gnt
//   pN_gnt                        - single-cycle grant, combinational from req
//   pN_rvalid/rdata/err           - read response, RD_LAT cycles after the grant
//   mem_address/mem_wren/mem_data - registered command to data_memory
//   mem_q                         - data_memory read data
module data_mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH  = MEM_DEPTH,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,

  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_q
);

  logic     last_q, last_d;
  addr_t    mem_address_q, mem_address_d;
  data_t    mem_data_q, mem_data_d;
  logic     mem_wren_q, mem_wren_d;

  logic     gnt0, gnt1, any_gnt;
  logic     win_id, win_we, in_range, oor_wr;
  addr_t    win_addr;
  data_t    win_wdata;
  rsp_tag_t tag_in, tag_out;
  logic     rsp0, rsp1;

  // Grants are gated by rst_n so that nothing is granted while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (p0_req && p1_req) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = p0_req;
        gnt1 = p1_req;
      end
    end
  end

  assign any_gnt   = gnt0 | gnt1;
  assign win_id    = gnt1;
  assign win_we    = win_id ? p1_we    : p0_we;
  assign win_addr  = win_id ? p1_addr  : p0_addr;
  assign win_wdata = win_id ? p1_wdata : p0_wdata;
  assign in_range  = addr_in_range(win_addr, DEPTH);
  assign oor_wr    = any_gnt & win_we & !in_range;

  // Issue path and response tag; address/data hold while idle, wren never does.
  always_comb begin
    last_d        = last_q;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    mem_wren_d    = 1'b0;
    tag_in        = '0;
    if (any_gnt) begin
      last_d        = win_id;
      mem_address_d = win_addr;
      mem_data_d    = win_wdata;
      mem_wren_d    = win_we & in_range;
      if (!win_we) begin
        tag_in.valid = 1'b1;
        tag_in.id    = win_id;
        tag_in.oor   = !in_range;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q        <= 1'b1;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_wren_q    <= 1'b0;
    end else begin
      last_q        <= last_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_wren_q    <= mem_wren_d;
    end
  end

  rsp_pipe #(
    .STAGES (RD_LAT)
  ) u_rsp_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign rsp0 = tag_out.valid & !tag_out.id;
  assign rsp1 = tag_out.valid &  tag_out.id;

  always_comb begin
    p0_gnt    = gnt0;
    p1_gnt    = gnt1;
    p0_rvalid = rsp0;
    p1_rvalid = rsp1;
    p0_rdata  = (rsp0 && !tag_out.oor) ? mem_q : '0;
    p1_rdata  = (rsp1 && !tag_out.oor) ? mem_q : '0;
    // err covers both a suppressed read response and a dropped write at grant time.
    p0_err    = (rsp0 & tag_out.oor) | (gnt0 & oor_wr);
    p1_err    = (rsp1 & tag_out.oor) | (gnt1 & oor_wr);
  end

  assign mem_address = mem_address_q;
  assign mem_wren    = mem_wren_q;
  assign mem_data    = mem_data_q;

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter sharing the single-port `data_memory` (19-bit byte address, 8-bit data, 307200 bytes = one 640x480 frame) between the processor load/store unit (port 0) and a frame streaming reader/writer (port 1). One access is issued per cycle, with round-robin fairness when both ports request. Out-of-range accesses are filtered, and read data is routed back to the issuing port with a fixed latency. It sits between the processor core and `data_memory`.

## Interface
- `DEPTH`, 307200: valid address range is 0..DEPTH-1 (0x00000..0x4AFFF).
- `RD_LAT`, 2: cycles from the grant cycle to the `rvalid` cycle. Must match the `data_memory` read path; legal range is 1..4.
- `clk` in, 1: single clock. All state is updated on the rising edge.
- `rst_n` in, 1: reset, asynchronous and active-low.
- `p0_req`/`p1_req` in, 1: access request. The requester must hold it until granted.
- `p0_we`/`p1_we` in, 1: 1 = write, 0 = read. Held stable with `req`.
- `p0_addr`/`p1_addr` in, 19: byte address. Held stable with `req`.
- `p0_wdata`/`p1_wdata` in, 8: write data. Held stable with `req`.
- `p0_gnt`/`p1_gnt` out, 1: one-cycle grant pulse. The request is consumed in that cycle.
- `p0_rvalid`/`p1_rvalid` out, 1: read response strobe.
- `p0_rdata`/`p1_rdata` out, 8: read data. Valid only while `rvalid` is high.
- `p0_err`/`p1_err` out, 1: qualifies `rvalid`. It also pulses with `gnt` for a dropped out-of-range write.
- `mem_address` out, 19: to `data_memory` `address`. Registered.
- `mem_wren` out, 1: to `data_memory` `wren`. Registered.
- `mem_data` out, 8: to `data_memory` `data`. Registered.
- `mem_q` in, 8: from `data_memory` `q`.

## Operation
- **State**
  - `last` (1 bit): port granted most recently. Reset value is 1, so port 0 wins the first tie.
  - Response pipeline: `RD_LAT` stages of {`valid`, `id`, `oor`}.
- **Arbitration** (combinational, each cycle)
  - Exactly one request: that port is granted.
  - Both request: the port ≠ `last` is granted.
  - Neither requests: no grant, and `last` is unchanged.
- **On a grant**
  - `last` ← winner.
  - The winner's `gnt` is high in that cycle. The other port's `gnt` stays low.
  - At most one `gnt` is high per cycle.
- **Issue** (registered at the end of the grant cycle)
  - `mem_address` ← the winner's address.
  - `mem_wren` ← `we & in_range`.
  - `mem_data` ← `wdata`.
  - With no grant, `mem_wren` ← 0 and `mem_address`/`mem_data` hold their values.
- **Range check**
  - `in_range` = `addr < DEPTH`, an unsigned 19-bit compare.
  - 0x4AFFF is in range. 0x4B000..0x7FFFF are out of range.
- **Out-of-range write**
  - Not issued: `mem_wren` stays 0.
  - `err` pulses together with `gnt`.
- **Read**
  - The pipeline stage-0 entry is {1, winner, !`in_range`}.
  - The read is still issued to memory even when out of range, to keep the latency fixed.
- **Response** (last pipeline stage with `valid` = 1)
  - `rvalid` is driven on the port matching `id`.
  - `rdata` = `oor` ? 8'h00 : `mem_q`.
  - `err` = `oor`.
  - `rdata` on the other port, and on both ports when idle, is 8'h00.
- **Ordering**: responses return in grant order. No reordering and no back-pressure; requesters must accept `rvalid` whenever it arrives.
- **Reset** (asynchronous assert, at any time including mid-access)
  - `mem_wren`=0, `mem_address`=0, `mem_data`=0.
  - The pipeline is cleared, so in-flight reads are discarded with no `rvalid`.
  - `last`=1.
  - All `gnt`/`rvalid`/`err`=0 and all `rdata`=0.
  - After `rst_n` rises, the first grant can occur in the first following cycle.

## Timing
- Grant latency:
  - Sole requester: 0 cycles (`gnt` in the same cycle as `req`).
  - Under contention: at most 1 cycle of wait.
- Throughput:
  - One access per cycle overall.
  - Continuous contention alternates p0, p1, p0, …
- The write is visible at the memory interface (`mem_wren` high) in grant cycle + 1.
- Read: `rvalid` is asserted in grant cycle + `RD_LAT`, for exactly one cycle per granted read.
- Back-to-back reads from mixed ports produce back-to-back `rvalid`s on the correct ports.
- A write immediately followed by a read of the same address returns the new data. `data_memory` is write-then-read ordered across cycles.

## Structure
- Package `mem_pkg` holds:
  - `ADDR_W`=19, `DATA_W`=8, `MEM_DEPTH`=307200.
  - `typedef logic [ADDR_W-1:0] addr_t`.
  - `typedef struct packed {logic valid; logic id; logic oor;} rsp_tag_t`.
- Single sub-module `rsp_pipe`: an `RD_LAT`-deep shift register of `rsp_tag_t` with async clear.
- The arbiter, range check and issue registers live in the top.

## Test plan
- **Reset defaults**: hold `rst_n`=0, drive `p0_req`=1 → no `gnt`, `mem_wren`=0, `mem_address`=0. Release → `p0_gnt` in the first cycle.
- **Single read**: p0 write 0x00001←8'hA5, then p0 read 0x00001 → `p0_rvalid` exactly `RD_LAT` cycles after its `gnt`, `p0_rdata`=8'hA5, `p0_err`=0.
- **Contention**: both ports hold read requests for 6 cycles after reset → grants p0,p1,p0,p1,p0,p1. Each `rvalid` appears on the matching port in order, with data matching pre-written 0x00000/0x4AFFF.
- **Boundary**:
  - Write to 0x4AFFF → issued.
  - Write to 0x4B000 → `mem_wren` stays 0, `err` pulses with `gnt`.
  - Read 0x4B000 → `rvalid`=1, `err`=1, `rdata`=8'h00.
- **Reset mid-read**: grant a p1 read, assert `rst_n`=0 one cycle later → no `p1_rvalid` ever, and all outputs are at reset values within the same cycle.
- **Idle and hold**: drop `p1_req` while waiting behind p0 → `p1_gnt` never pulses and `last` is not updated. Idle cycles keep `mem_wren`=0.
